// File: rtl/ysyx_22050243_core_seq_pkg.sv
// ysyx_22050243_core_seq_pkg
//   Shared definitions for the multi-cycle sequencer: state encodings,
//   halt codes and a helper that identifies the states in which the core
//   waits on a memory port (and is therefore watched by the watchdog).
package ysyx_22050243_core_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    localparam logic [1:0] HC_RUN     = 2'b00;
    localparam logic [1:0] HC_EBREAK  = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_BUS     = 2'b11;

    // States that wait on an external handshake and may stall forever.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_IF) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/ysyx_22050243_wdog.sv
// ysyx_22050243_wdog
//   Stall watchdog. Counts enabled cycles since the last clear and flags
//   expiry during the TIMEOUT-th consecutive enabled cycle, so the owner
//   can leave the stalled state on that same edge.
// Ports
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   clr      in   reload the counter with zero
//   en       in   count this cycle
//   expired  out  TIMEOUT enabled cycles reached (combinational)
module ysyx_22050243_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !expired) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    // cnt_reg holds the number of earlier waiting cycles, so TIMEOUT-1
    // means the current cycle is the TIMEOUT-th one.
    assign expired = en && (cnt_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_22050243_core_seq.sv
// ysyx_22050243_core_seq
//   Multi-cycle sequencer for the RV64 NPC datapath: IF -> ID -> EX ->
//   [MEM] -> WB. Handshakes with the instruction/data ports, gates the
//   architectural write strobes, counts cycles and retired instructions,
//   and halts on ebreak, illegal opcode, bus error or stall timeout.
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   ifu_req/ready/rvalid/err      instruction fetch handshake
//   ir_wen                        latch instruction register
//   dec_*                         decoder control bits, sampled in ID
//   lsu_req/we/ready/done/err     data memory handshake
//   rf_wen, csr_wen, pc_wen       write strobes, asserted in WB
//   halt, halt_code               core stopped and why
//   state                         current state (debug)
//   cycle_cnt, instret_cnt        free-running counters, wrap silently
module ysyx_22050243_core_seq
    import ysyx_22050243_core_seq_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req,
    input  logic             ifu_ready,
    input  logic             ifu_rvalid,
    input  logic             ifu_err,
    output logic             ir_wen,
    input  logic             dec_mem_r,
    input  logic             dec_mem_w,
    input  logic             dec_reg_w,
    input  logic             dec_csr_r,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    output logic             lsu_req,
    output logic             lsu_we,
    input  logic             lsu_ready,
    input  logic             lsu_done,
    input  logic             lsu_err,
    output logic             rf_wen,
    output logic             csr_wen,
    output logic             pc_wen,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    state_t           state_reg, state_next;
    logic [1:0]       halt_code_reg, halt_code_next;
    logic             mem_r_reg, mem_w_reg, reg_w_reg, csr_r_reg;
    logic             if_acc_reg, lsu_acc_reg;   // request accepted, awaiting data
    logic [CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg;
    logic             wd_en, wd_expired;

    assign wd_en = is_wait_state(state_reg);

    // Clearing whenever we are outside IF/MEM means every entry into a
    // waiting state starts from zero.
    ysyx_22050243_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!wd_en),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_next     = state_reg;
        halt_code_next = halt_code_reg;
        ifu_req        = 1'b0;
        ir_wen         = 1'b0;
        lsu_req        = 1'b0;
        lsu_we         = 1'b0;
        rf_wen         = 1'b0;
        csr_wen        = 1'b0;
        pc_wen         = 1'b0;
        case (state_reg)
            ST_RST: state_next = ST_IF;
            ST_IF: begin
                ifu_req = !if_acc_reg;
                // A completing response beats a watchdog expiry in the same cycle.
                if (ifu_rvalid) begin
                    if (ifu_err) begin
                        state_next     = ST_HALT;
                        halt_code_next = HC_BUS;
                    end else begin
                        ir_wen     = 1'b1;
                        state_next = ST_ID;
                    end
                end else if (wd_expired) begin
                    state_next     = ST_HALT;
                    halt_code_next = HC_BUS;
                end
            end
            ST_ID: begin
                if (dec_illegal) begin
                    state_next     = ST_HALT;
                    halt_code_next = HC_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_next     = ST_HALT;
                    halt_code_next = HC_EBREAK;
                end else begin
                    state_next = ST_EX;
                end
            end
            ST_EX: state_next = (mem_r_reg || mem_w_reg) ? ST_MEM : ST_WB;
            ST_MEM: begin
                lsu_req = !lsu_acc_reg;
                lsu_we  = !lsu_acc_reg && mem_w_reg;
                if (lsu_done) begin
                    if (lsu_err) begin
                        state_next     = ST_HALT;
                        halt_code_next = HC_BUS;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wd_expired) begin
                    state_next     = ST_HALT;
                    halt_code_next = HC_BUS;
                end
            end
            ST_WB: begin
                rf_wen     = reg_w_reg;
                csr_wen    = csr_r_reg;
                pc_wen     = 1'b1;
                state_next = ST_IF;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_RST;
            halt_code_reg   <= HC_RUN;
            mem_r_reg       <= 1'b0;
            mem_w_reg       <= 1'b0;
            reg_w_reg       <= 1'b0;
            csr_r_reg       <= 1'b0;
            if_acc_reg      <= 1'b0;
            lsu_acc_reg     <= 1'b0;
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            halt_code_reg <= halt_code_next;
            // Accept flags live only while we stay in the owning state.
            if_acc_reg  <= (state_next == ST_IF)  && (if_acc_reg  || (ifu_req && ifu_ready));
            lsu_acc_reg <= (state_next == ST_MEM) && (lsu_acc_reg || (lsu_req && lsu_ready));
            if (state_reg == ST_ID) begin
                mem_r_reg <= dec_mem_r;
                mem_w_reg <= dec_mem_w;
                reg_w_reg <= dec_reg_w;
                csr_r_reg <= dec_csr_r;
            end
            if (state_reg != ST_RST && state_reg != ST_HALT) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            if (state_reg == ST_WB) begin
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign halt        = (state_reg == ST_HALT);
    assign halt_code   = halt_code_reg;
    assign state       = state_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_ysyx_22050243_core_seq.sv
// tb_ysyx_22050243_core_seq
//   Directed bench. Each instruction scenario is expanded up front into a
//   per-cycle timeline of input vectors and required outputs (phase lengths
//   follow from the memory latencies chosen for that scenario); the run then
//   replays the inputs and compares every output on every cycle, plus a few
//   hand-computed counter/halt-code values at chosen cycles.
module tb_ysyx_22050243_core_seq;

    localparam int CNT_W   = 64;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n, ifu_req, ifu_ready, ifu_rvalid, ifu_err, ir_wen;
    logic dec_mem_r, dec_mem_w, dec_reg_w, dec_csr_r, dec_ebreak, dec_illegal;
    logic lsu_req, lsu_we, lsu_ready, lsu_done, lsu_err;
    logic rf_wen, csr_wen, pc_wen, halt;
    logic [1:0] halt_code;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    ysyx_22050243_core_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
        .ir_wen(ir_wen),
        .dec_mem_r(dec_mem_r), .dec_mem_w(dec_mem_w), .dec_reg_w(dec_reg_w),
        .dec_csr_r(dec_csr_r), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ready(lsu_ready), .lsu_done(lsu_done),
        .lsu_err(lsu_err),
        .rf_wen(rf_wen), .csr_wen(csr_wen), .pc_wen(pc_wen),
        .halt(halt), .halt_code(halt_code), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct packed {
        logic rst_n, ifu_ready, ifu_rvalid, ifu_err;
        logic mem_r, mem_w, reg_w, csr_r, ebreak, illegal;
        logic lsu_ready, lsu_done, lsu_err;
    } stim_t;

    typedef struct packed {
        logic        chk;
        logic        ifu_req, ir_wen, lsu_req, lsu_we, rf_wen, csr_wen, pc_wen, halt;
        logic [1:0]  halt_code;
        logic [63:0] cycle_cnt, instret_cnt;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    string notes[int];
    int          lit_idx[$];
    logic [63:0] lit_cyc[$], lit_ins[$];
    logic [1:0]  lit_code[$];

    logic [63:0] m_cyc, m_ins;
    logic [1:0]  m_code;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic stim_t idle_s();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic exp_t run_e();
        exp_t e;
        e     = '0;
        e.chk = 1'b1;
        return e;
    endfunction

    // Append one cycle; counters shown are those accumulated before it.
    task automatic push(input stim_t s, input exp_t e, input bit active);
        e.cycle_cnt   = m_cyc;
        e.instret_cnt = m_ins;
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (active) m_cyc = m_cyc + 64'd1;
    endtask

    // First low cycle still shows the old state; later ones and the first
    // released cycle show the idle reset state.
    task automatic reset_seq(input int low);
        stim_t s;
        exp_t  e;
        s       = '0;
        e       = '0;
        push(s, e, 1'b0);
        m_cyc   = '0;
        m_ins   = '0;
        e.chk   = 1'b1;
        for (int i = 1; i < low; i++) push(s, e, 1'b0);
        s.rst_n = 1'b1;
        push(s, e, 1'b0);
    endtask

    // Halted: inputs are busy, everything must stay quiet and frozen.
    task automatic halt_seq(input int n, input logic [1:0] code);
        stim_t s;
        exp_t  e;
        s = idle_s();
        s.ifu_ready = 1'b1; s.ifu_rvalid = 1'b1; s.lsu_ready = 1'b1; s.lsu_done = 1'b1;
        s.reg_w = 1'b1;
        e = run_e();
        e.halt = 1'b1;
        e.halt_code = code;
        for (int i = 0; i < n; i++) push(s, e, 1'b0);
    endtask

    task automatic fetch(input int fa, input int fv, input bit ferr);
        stim_t s;
        exp_t  e;
        for (int k = 0; k <= fv; k++) begin
            s = idle_s();
            s.ifu_ready  = (k == fa);
            s.ifu_rvalid = (k == fv);
            s.ifu_err    = (k == fv) && ferr;
            e = run_e();
            e.ifu_req = (k <= fa);
            e.ir_wen  = (k == fv) && !ferr;
            push(s, e, 1'b1);
        end
    endtask

    // rst_k >= 0 pulls reset during that MEM wait cycle.
    task automatic instr(input string label, input bit reg_w, input bit csr_r,
                         input bit mem_r, input bit mem_w, input bit ebreak,
                         input bit illegal, input int fa, input int fv,
                         input int la, input int ld, input bit lerr, input int rst_k);
        stim_t s;
        exp_t  e;
        notes[stim_q.size()] = label;
        fetch(fa, fv, 1'b0);
        s = idle_s();
        s.reg_w = reg_w; s.csr_r = csr_r; s.mem_r = mem_r; s.mem_w = mem_w;
        s.ebreak = ebreak; s.illegal = illegal;
        push(s, run_e(), 1'b1);
        if (illegal) begin halt_seq(4, 2'b10); return; end
        if (ebreak)  begin halt_seq(4, 2'b01); return; end
        push(idle_s(), run_e(), 1'b1);
        if (mem_r || mem_w) begin
            for (int k = 0; k <= ld; k++) begin
                if (k == rst_k) begin reset_seq(1); return; end
                s = idle_s();
                s.lsu_ready = (k == la);
                s.lsu_done  = (k == ld);
                s.lsu_err   = (k == ld) && lerr;
                e = run_e();
                e.lsu_req = (k <= la);
                e.lsu_we  = (k <= la) && mem_w;
                push(s, e, 1'b1);
            end
            if (lerr) begin halt_seq(4, 2'b11); return; end
        end
        e = run_e();
        e.rf_wen  = reg_w;
        e.csr_wen = csr_r;
        e.pc_wen  = 1'b1;
        push(idle_s(), e, 1'b1);
        m_ins = m_ins + 64'd1;
    endtask

    task automatic lit(input int idx, input logic [63:0] c, input logic [63:0] i,
                       input logic [1:0] code);
        lit_idx.push_back(idx);
        lit_cyc.push_back(c);
        lit_ins.push_back(i);
        lit_code.push_back(code);
    endtask

    task automatic chk(input string name, input int t, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, required %0h", name, t, act, req);
        end
    endtask

    task automatic build();
        exp_t e;
        m_cyc = '0; m_ins = '0; m_code = 2'b00;
        reset_seq(2);
        instr("addi zero-wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        lit(stim_q.size(), 64'd4, 64'd1, 2'b00);
        instr("lw ready+2 done+5", 1, 0, 1, 0, 0, 0, 1, 2, 2, 5, 0, -1);
        instr("sw zero-wait", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
        lit(stim_q.size(), 64'd21, 64'd3, 2'b00);
        instr("csrrw", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        lit(stim_q.size() + 2, 64'd27, 64'd4, 2'b01);
        instr("ebreak", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, -1);
        reset_seq(1);
        lit(stim_q.size() + 2, 64'd2, 64'd0, 2'b10);
        instr("ebreak+illegal", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, -1);
        reset_seq(1);
        instr("lw reset mid-MEM", 1, 0, 1, 0, 0, 0, 0, 0, 3, 5, 0, 2);
        instr("addi after reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        lit(stim_q.size(), 64'd4, 64'd1, 2'b00);
        notes[stim_q.size()] = "fetch timeout";
        for (int k = 0; k < TIMEOUT; k++) begin
            e = run_e();
            e.ifu_req = 1'b1;
            push(idle_s(), e, 1'b1);
        end
        lit(stim_q.size(), 64'd12, 64'd1, 2'b11);
        halt_seq(4, 2'b11);
        reset_seq(1);
        notes[stim_q.size()] = "fetch bus error";
        fetch(0, 1, 1'b1);
        lit(stim_q.size(), 64'd2, 64'd0, 2'b11);
        halt_seq(3, 2'b11);
        reset_seq(1);
        instr("sw bus error", 0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 1, -1);
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        rst_n = 1'b0;
        {ifu_ready, ifu_rvalid, ifu_err, lsu_ready, lsu_done, lsu_err} = '0;
        {dec_mem_r, dec_mem_w, dec_reg_w, dec_csr_r, dec_ebreak, dec_illegal} = '0;
        build();
        @(posedge clk);
        #1;
        for (int t = 0; t < stim_q.size(); t++) begin
            s = stim_q[t];
            e = exp_q[t];
            rst_n = s.rst_n;
            ifu_ready = s.ifu_ready; ifu_rvalid = s.ifu_rvalid; ifu_err = s.ifu_err;
            dec_mem_r = s.mem_r; dec_mem_w = s.mem_w; dec_reg_w = s.reg_w;
            dec_csr_r = s.csr_r; dec_ebreak = s.ebreak; dec_illegal = s.illegal;
            lsu_ready = s.lsu_ready; lsu_done = s.lsu_done; lsu_err = s.lsu_err;
            if (notes.exists(t)) $display("tb: cycle %0d start %s", t, notes[t]);
            @(negedge clk);
            if (e.chk) begin
                chk("ifu_req", t, ifu_req, e.ifu_req);
                chk("ir_wen", t, ir_wen, e.ir_wen);
                chk("lsu_req", t, lsu_req, e.lsu_req);
                if (e.lsu_req) chk("lsu_we", t, lsu_we, e.lsu_we);
                chk("rf_wen", t, rf_wen, e.rf_wen);
                chk("csr_wen", t, csr_wen, e.csr_wen);
                chk("pc_wen", t, pc_wen, e.pc_wen);
                chk("halt", t, halt, e.halt);
                chk("halt_code", t, halt_code, e.halt_code);
                chk("cycle_cnt", t, cycle_cnt, e.cycle_cnt);
                chk("instret_cnt", t, instret_cnt, e.instret_cnt);
            end
            for (int i = 0; i < lit_idx.size(); i++) begin
                if (lit_idx[i] == t) begin
                    chk("lit_cycle_cnt", t, cycle_cnt, lit_cyc[i]);
                    chk("lit_instret", t, instret_cnt, lit_ins[i]);
                    chk("lit_halt_code", t, halt_code, lit_code[i]);
                end
            end
            @(posedge clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
